// File: rtl/adder_tree_pkg.sv
// Shared types and elaboration helpers for the pipelined signed adder tree.
package adder_tree_pkg;

  // Control sideband that travels alongside each beat through every stage
  typedef struct packed {
    logic valid;
    logic last;
    logic acc_mode;
  } side_t;

  // Number of pairwise adder levels needed to reduce n operands to one
  function automatic int tree_levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Operand width entering level k of a tree whose leaves are w bits wide
  function automatic int level_width(input int w, input int k);
    return w + k;
  endfunction

  // Operand count entering level k of a tree with n leaves
  function automatic int level_count(input int n, input int k);
    return (n + (1 << k) - 1) >> k;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: pairwise signed adds, odd operand
// passes through sign-extended, shared advance enable for the whole pipeline.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int W_IN  = 16,
  localparam int N_OUT = (N_IN + 1) / 2,
  localparam int W_OUT = W_IN + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   advance_i,
  input  side_t                  side_i,
  input  logic [N_IN*W_IN-1:0]   d_i,
  output side_t                  side_o,
  output logic [N_OUT*W_OUT-1:0] q_o
);

  localparam int PAD_W = 2 * N_OUT * W_IN;

  logic [PAD_W-1:0]       d_pad;
  logic [N_OUT*W_OUT-1:0] sum_d;
  logic [N_OUT*W_OUT-1:0] sum_q;
  side_t                  side_q;

  function automatic logic signed [W_OUT-1:0] add_pair(input logic signed [W_IN-1:0] a,
                                                       input logic signed [W_IN-1:0] b);
    return W_OUT'(a) + W_OUT'(b);
  endfunction

  // An odd operand count is padded with a zero operand, so the leftover
  // simply adds to zero and emerges sign-extended.
  assign d_pad = PAD_W'(d_i);

  // Pairwise sums for every output slot
  always_comb begin
    sum_d = '0;
    for (int j = 0; j < N_OUT; j++) begin
      sum_d[j*W_OUT +: W_OUT] = add_pair(d_pad[2*j*W_IN +: W_IN], d_pad[(2*j+1)*W_IN +: W_IN]);
    end
  end

  // Sideband register: cleared by reset, shifts only on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         side_q <= '0;
    else if (advance_i) side_q <= side_i;
  end

  // Data register: no reset needed, qualified by the sideband valid
  always_ff @(posedge clk) begin
    if (advance_i) sum_q <= sum_d;
  end

  assign side_o = side_q;
  assign q_o    = sum_q;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined, backpressure-aware signed adder tree with optional frame
// accumulation. Input register -> LEVELS adder registers -> output/accumulator.
// A single global advance stalls every stage; bubbles are kept in place.
module pipelined_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int NUM_INPUT     = 8,
  parameter int DATA_WIDTH_IN = 16,
  parameter int ACC_EXT_BITS  = 8,
  localparam int LEVELS = tree_levels(NUM_INPUT),
  localparam int SUM_W  = DATA_WIDTH_IN + LEVELS,
  localparam int OUT_W  = SUM_W + ACC_EXT_BITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [DATA_WIDTH_IN-1:0] din [NUM_INPUT],
  input  logic                            in_last,
  input  logic                            acc_mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [OUT_W-1:0]         dout,
  output logic                            out_last,
  output logic                            out_overflow
);

  if (DATA_WIDTH_IN <= 0) begin : g_chk_width
    $error("pipelined_adder_tree: DATA_WIDTH_IN must be > 0");
  end
  if (NUM_INPUT < 1) begin : g_chk_count
    $error("pipelined_adder_tree: NUM_INPUT must be >= 1");
  end
  if (ACC_EXT_BITS < 0) begin : g_chk_ext
    $error("pipelined_adder_tree: ACC_EXT_BITS must be >= 0");
  end

  function automatic logic signed_wrap(input logic signed [OUT_W-1:0] a,
                                       input logic signed [OUT_W-1:0] b,
                                       input logic signed [OUT_W-1:0] s);
    return (a[OUT_W-1] == b[OUT_W-1]) && (s[OUT_W-1] != a[OUT_W-1]);
  endfunction

  logic                               advance;
  logic [NUM_INPUT*DATA_WIDTH_IN-1:0] in_flat_d, in_flat_q;
  side_t                              in_side_q;
  logic signed [SUM_W-1:0]            tree_sum;
  side_t                              tree_side;

  logic                    out_valid_d, out_valid_q;
  logic signed [OUT_W-1:0] dout_d, dout_q;
  logic                    out_last_d, out_last_q;
  logic                    out_ovf_d, out_ovf_q;
  logic signed [OUT_W-1:0] acc_d, acc_q;
  logic                    flag_d, flag_q;
  logic signed [OUT_W-1:0] sum_ext, acc_add;
  logic                    add_wrap;

  // The whole pipeline moves whenever the output slot is free or being drained
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Pack the operand array into a flat bus for the tree levels
  always_comb begin
    in_flat_d = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      in_flat_d[i*DATA_WIDTH_IN +: DATA_WIDTH_IN] = din[i];
    end
  end

  // Input stage sideband: in_ready equals advance, so a present beat is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       in_side_q <= '0;
    else if (advance) in_side_q <= '{valid: in_valid, last: in_last, acc_mode: acc_mode};
  end

  // Input stage operands
  always_ff @(posedge clk) begin
    if (advance) in_flat_q <= in_flat_d;
  end

  if (LEVELS == 0) begin : g_no_tree
    assign tree_sum  = $signed(in_flat_q);
    assign tree_side = in_side_q;
  end else begin : g_tree
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int NI = level_count(NUM_INPUT, k);
      localparam int WI = level_width(DATA_WIDTH_IN, k);
      localparam int NO = level_count(NUM_INPUT, k + 1);
      logic [NI*WI-1:0]     d;
      logic [NO*(WI+1)-1:0] q;
      side_t                s_in;
      side_t                side;
      if (k == 0) begin : g_src
        assign d    = in_flat_q;
        assign s_in = in_side_q;
      end else begin : g_src
        assign d    = g_lvl[k-1].q;
        assign s_in = g_lvl[k-1].side;
      end
      adder_tree_level #(.N_IN(NI), .W_IN(WI)) u_level (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance_i (advance),
        .side_i    (s_in),
        .d_i       (d),
        .side_o    (side),
        .q_o       (q)
      );
    end
    assign tree_sum  = $signed(g_lvl[LEVELS-1].q);
    assign tree_side = g_lvl[LEVELS-1].side;
  end

  assign sum_ext  = OUT_W'(tree_sum);
  assign acc_add  = acc_q + sum_ext;
  assign add_wrap = signed_wrap(acc_q, sum_ext, acc_add);

  // Output / accumulator next state: pass-through, accumulate, or close a frame
  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    out_last_d  = out_last_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    flag_d      = flag_q;
    if (advance) begin
      out_valid_d = 1'b0;
      if (tree_side.valid) begin
        if (!tree_side.acc_mode) begin
          out_valid_d = 1'b1;
          dout_d      = sum_ext;
          out_last_d  = tree_side.last;
          out_ovf_d   = 1'b0;
        end else if (!tree_side.last) begin
          acc_d  = acc_add;
          flag_d = flag_q | add_wrap;
        end else begin
          out_valid_d = 1'b1;
          dout_d      = acc_add;
          out_last_d  = 1'b1;
          out_ovf_d   = flag_q | add_wrap;
          acc_d       = '0;
          flag_d      = 1'b0;
        end
      end
    end
  end

  // Output / accumulator registers; reset discards any open frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
      flag_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      out_last_q  <= out_last_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
      flag_q      <= flag_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign dout         = dout_q;
  assign out_last     = out_last_q;
  assign out_overflow = out_ovf_q;

endmodule
